// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Imported by ifq_fifo and ifetch_queue.
package ifetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } ifq_state_t;

    localparam logic [31:0] IFQ_NOP = 32'h0000_0013;

    function automatic logic [31:0] ifq_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Registered FIFO of fetched instruction entries.
// Flush clears pointers and count and overrides push and pop.
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  ifq_entry_t         wdata,
    output logic               full,
    output logic               empty,
    output logic [PTR_WIDTH:0] count,
    output ifq_entry_t         head
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] DEPTH_C = CW'(DEPTH);

    ifq_entry_t           mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; a slot is only read after it has been written
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Sequential fetch front-end with in-order response FIFO and redirect flush.
// Optional IFETCH_QUEUE_BYPASS_EN presents a response to decode in its arrival cycle.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          PTR_WIDTH = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_b,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int SW = PTR_WIDTH + 2;
    localparam int CW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH+1:0] DEPTH_S = SW'(DEPTH);
    localparam logic [PTR_WIDTH:0]   ONE_C   = CW'(1);

    ifq_state_t           state;
    logic [31:0]          fetch_pc;
    logic [31:0]          rsp_pc;
    logic [31:0]          target;
    logic [PTR_WIDTH:0]   outstanding;
    logic [PTR_WIDTH:0]   outstanding_next;
    logic [PTR_WIDTH:0]   stale;
    logic [PTR_WIDTH:0]   count;
    logic [PTR_WIDTH+1:0] inflight;
    logic                 full;
    logic                 empty;
    logic                 req_fire;
    logic                 rsp_keep;
    logic                 bypass;
    logic                 push;
    logic                 pop;
    logic [1:0]           unused_pc_lsb;
    ifq_entry_t           head;
    ifq_entry_t           wdata;

    assign unused_pc_lsb = redirect_pc[1:0];
    assign target        = ifq_align(redirect_pc);

    assign inflight      = {1'b0, count} + {1'b0, outstanding};
    assign mem_req_valid = (state == FETCH) && !redirect_valid
                           && (inflight < DEPTH_S);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_keep = mem_rsp_valid && (stale == '0) && !redirect_valid;

`ifdef IFETCH_QUEUE_BYPASS_EN
    assign bypass = rsp_keep && empty;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid = !empty || bypass;
    assign inst       = !empty ? head.inst : (bypass ? mem_rsp_data : '0);
    assign inst_pc    = !empty ? head.pc : (bypass ? rsp_pc : '0);
    assign pop        = !empty && inst_ready;
    assign push       = rsp_keep && !(bypass && inst_ready);
    assign wdata      = '{pc: rsp_pc, inst: mem_rsp_data};

    // Requests in flight after this cycle's accept and response
    always_comb begin
        outstanding_next = outstanding;
        if (req_fire) begin
            outstanding_next = outstanding_next + 1'b1;
        end
        if (mem_rsp_valid) begin
            outstanding_next = outstanding_next - 1'b1;
        end
    end

    // Fetch/response PCs, stale drain count and FETCH/DRAIN control
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (redirect_valid) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                stale    <= outstanding_next;
                state    <= (outstanding_next != '0) ? DRAIN : FETCH;
            end else if (mem_rsp_valid && (stale != '0)) begin
                stale <= stale - 1'b1;
                if (stale == ONE_C) begin
                    state <= FETCH;
                end
            end
        end
    end

    ifq_fifo #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wdata   (wdata),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .head    (head)
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset_b) !(mem_rsp_valid && full)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: bench-side memory and stream model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    localparam int DEPTH = 4;
`ifdef IFETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_b;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH     (4),
        .PTR_WIDTH (2),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] mpc[$];
    logic [31:0] mdat[$];
    logic [31:0] req_log[$];
    logic [31:0] con_log[$];
    logic [31:0] exp_req;
    logic [31:0] exp_stream;
    int          mstale;
    int          lat = 2;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    int          dropped = 0;
    int          first_rsp = -1;
    int          first_iv = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        tick(3);
        reset_b = 1'b1;
    endtask

    // memory: presents the oldest pending response once its latency expires
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset_b && pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_word(pend[0].addr);
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
            end
        end
    end

    // per-cycle compare, then advance the model across the coming edge
    always @(negedge clk) begin
        bit          rsp, byp, exp_iv, exp_rv, fire;
        logic [31:0] ra, epc, edat;
        if (!reset_b) begin
            chk("rst_inst_valid", 32'(inst_valid), 32'd0);
            chk("rst_inst", inst, 32'd0);
            chk("rst_inst_pc", inst_pc, 32'd0);
            pend.delete();
            mpc.delete();
            mdat.delete();
            req_log.delete();
            con_log.delete();
            mstale     = 0;
            exp_req    = 32'h0;
            exp_stream = 32'h0;
            dropped    = 0;
            first_rsp  = -1;
            first_iv   = -1;
        end else begin
            rsp = mem_rsp_valid;
            ra  = (rsp && pend.size() > 0) ? pend[0].addr : 32'h0;
            byp = BYP && mpc.size() == 0 && rsp && mstale == 0
                  && !redirect_valid;
            exp_iv = (mpc.size() != 0) || byp;
            if (mpc.size() != 0) begin
                epc  = mpc[0];
                edat = mdat[0];
            end else begin
                epc  = ra;
                edat = mem_word(ra);
            end
            exp_rv = !redirect_valid && mstale == 0
                     && (mpc.size() + pend.size() < DEPTH);
            chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
            chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_rv));
            if (exp_iv && inst_valid) begin
                chk("inst_pc", inst_pc, epc);
                chk("inst", inst, edat);
            end
            if (exp_rv && mem_req_valid) begin
                chk("mem_req_addr", mem_req_addr, exp_req);
            end
            if (rsp && first_rsp < 0) first_rsp = cyc;
            if (inst_valid && first_iv < 0) first_iv = cyc;

            fire = inst_valid && inst_ready;
            if (fire) begin
                chk("stream_pc", inst_pc, exp_stream);
                con_log.push_back(inst_pc);
                exp_stream = exp_stream + 32'd4;
                if (mpc.size() != 0) begin
                    void'(mpc.pop_front());
                    void'(mdat.pop_front());
                end
            end
            if (rsp && pend.size() > 0) void'(pend.pop_front());
            if (mem_req_valid && mem_req_ready) begin
                req_log.push_back(mem_req_addr);
                pend.push_back('{addr: mem_req_addr, due: cyc + lat});
                exp_req = mem_req_addr + 32'd4;
            end
            if (redirect_valid) begin
                mpc.delete();
                mdat.delete();
                if (rsp) dropped++;
                mstale     = pend.size();
                exp_req    = {redirect_pc[31:2], 2'b00};
                exp_stream = {redirect_pc[31:2], 2'b00};
            end else if (rsp) begin
                if (mstale > 0) begin
                    mstale--;
                    dropped++;
                end else if (!(byp && inst_ready)) begin
                    mpc.push_back(ra);
                    mdat.push_back(mem_word(ra));
                end
            end
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_b        = 1'b0;
        mem_req_ready  = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick(3);

        // sequential stream, 2-cycle latency, decode always ready
        lat = 2;
        reset_b = 1'b1;
        tick(20);
        for (int i = 0; i < 4; i++) begin
            chk("t1_req_addr", at(req_log, i), 32'(4 * i));
            chk("t1_inst_pc", at(con_log, i), 32'(4 * i));
        end

        // decode stalled: queue fills, one pop frees one request
        lat = 1;
        inst_ready = 1'b0;
        do_reset();
        tick(12);
        chk("t2_req_count", 32'(req_log.size()), 32'd4);
        inst_ready = 1'b1;
        tick(1);
        inst_ready = 1'b0;
        tick(8);
        chk("t2_req_count_after_pop", 32'(req_log.size()), 32'd5);
        chk("t2_fifth_addr", at(req_log, 4), 32'h10);
        chk("t2_popped_pc", at(con_log, 0), 32'h0);

        // redirect with three requests in flight
        lat = 4;
        inst_ready = 1'b1;
        do_reset();
        n = 0;
        while (req_log.size() < 3 && n < 20) begin
            tick(1);
            n++;
        end
        chk("t3_setup_reqs", 32'(req_log.size()), 32'd3);
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick(1);
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b1;
        tick(16);
        chk("t3_dropped", 32'(dropped), 32'd3);
        chk("t3_first_new_req", at(req_log, 3), 32'h100);
        chk("t3_first_inst_pc", at(con_log, 0), 32'h100);

        // redirect coinciding with a response and a decode handshake
        lat = 2;
        inst_ready = 1'b0;
        do_reset();
        n = 0;
        while (!(mpc.size() >= 1 && mem_rsp_valid) && n < 20) begin
            tick(1);
            n++;
        end
        chk("t4_setup_valid", 32'(inst_valid), 32'd1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick(1);
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        chk("t4_valid_after_redirect", 32'(inst_valid), 32'd0);
        tick(6);
        chk("t4_dropped", 32'(dropped), 32'd2);
        inst_ready = 1'b1;
        tick(10);
        chk("t4_consumed_first", at(con_log, 0), 32'h0);
        chk("t4_consumed_next", at(con_log, 1), 32'h200);

        // fetch address wraps past the top of the address space
        lat = 1;
        inst_ready = 1'b1;
        do_reset();
        tick(5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick(1);
        redirect_valid = 1'b0;
        req_log.delete();
        con_log.delete();
        tick(12);
        chk("t5_req_top", at(req_log, 0), 32'hFFFF_FFFC);
        chk("t5_req_wrap", at(req_log, 1), 32'h0);
        chk("t5_pc_top", at(con_log, 0), 32'hFFFF_FFFC);
        chk("t5_pc_wrap", at(con_log, 1), 32'h0);

        // response-to-inst_valid latency from an empty queue
        lat = 3;
        inst_ready = 1'b1;
        do_reset();
        tick(10);
        chk("t6_rsp_seen", 32'(first_rsp >= 0), 32'd1);
        chk("t6_latency", 32'(first_iv - first_rsp), BYP ? 32'd0 : 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front-end that replaces the zero-latency instruction memory port in front of the CPU core.
- Issues sequential word fetches to a variable-latency instruction memory and buffers in-order responses in a small FIFO.
- Presents instruction and PC to the decode stage with a valid/ready handshake.
- On a control-flow redirect (taken branch, jal, jalr), flushes the FIFO and discards in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries; also the maximum number of outstanding memory requests (power of 2, ≥2).
- PTR_WIDTH, 2, log2(DEPTH).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock
- reset_b  in  1  reset; asynchronous, active-low
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_req_addr  out  32  byte address of the request, word aligned
- mem_rsp_valid  in  1  response valid; responses return in request order, latency ≥1 cycle
- mem_rsp_data  in  32  fetched instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored
- inst_valid  out  1  head entry valid
- inst_ready  in  1  decode consumes the head entry
- inst  out  32  head instruction
- inst_pc  out  32  PC of the head instruction

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC, rsp_pc = RESET_PC
  - count = 0, outstanding = 0, stale = 0, state = FETCH
  - mem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0
- Requests:
  - mem_req_valid = (state==FETCH) && !redirect_valid && (count + outstanding < DEPTH).
  - mem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (mod 2^32) and outstanding += 1.
  - The memory must not act on a request unless ready is high. valid may drop without acceptance only on redirect.
- Responses:
  - Each mem_rsp_valid decrements outstanding.
  - If stale != 0, the response is dropped and stale is decremented.
  - Otherwise mem_rsp_data is written to the FIFO with pc = rsp_pc, and rsp_pc += 4.
  - Overflow is impossible by construction. A response arriving while count==DEPTH is an assertion failure.
- Consume:
  - inst_valid = (count != 0); inst and inst_pc come from the head entry.
  - On inst_valid && inst_ready: the head is popped.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority), in the redirect cycle:
  - The inst handshake is honoured; the entry is consumed.
  - The FIFO is cleared: count = 0, pointers = 0.
  - fetch_pc and rsp_pc are set to {redirect_pc[31:2], 2'b00}.
  - stale = outstanding_next, where outstanding_next already includes a response decrement from this cycle. A response arriving in the redirect cycle is itself dropped.
  - Next state: DRAIN if stale != 0, else FETCH.
  - inst_valid is 0 from the next cycle until a new-stream response is written.
- FSM:
  - FETCH: normal operation.
  - DRAIN: no requests. When the last stale response arrives (stale 1→0), go to FETCH. A request may issue in the following cycle.
  - A redirect in DRAIN reloads fetch_pc and rsp_pc, keeps stale = outstanding_next, and stays in DRAIN.
- Latency:
  - Response to inst_valid is 1 cycle (registered FIFO).
  - Redirect to first mem_req_valid is 1 cycle when nothing is in flight.
- Asynchronous reset mid-operation returns to the reset values. In-flight memory responses after reset are the memory's responsibility, since the memory shares the same reset.

Optional Feature:
- IFETCH_QUEUE_BYPASS_EN
- Defined:
  - When count==0 and a non-stale response arrives, inst_valid=1 combinationally that cycle, with inst=mem_rsp_data and inst_pc=rsp_pc.
  - If inst_ready is also high, the response is consumed and not written.
  - Bypass is suppressed in a redirect cycle.
- Undefined: a response is always written first and seen 1 cycle later.

Decomposition:
- Package ifetch_queue_pkg:
  - typedef ifq_entry_t {logic [31:0] pc; logic [31:0] inst;}
  - enum ifq_state_t {FETCH, DRAIN}
  - constant IFQ_NOP = 32'h0000_0013
- Sub-module ifq_fifo:
  - Parameterised by DEPTH/PTR_WIDTH, storing ifq_entry_t.
  - Ports: push, pop, flush, full, empty, count, head.
  - Flush overrides push and pop.

Test Plan:
- Reset release, mem_req_ready=1, fixed 2-cycle response latency, inst_ready=1: requests go to 0x0,0x4,0x8,0xC, and inst_pc is seen in the same order with matching data.
- inst_ready=0, memory always ready: exactly 4 requests issue, mem_req_valid stays 0 with count=4, then one pop allows exactly one new request at 0x10.
- 3 requests outstanding at 0x0/0x4/0x8, redirect_pc=0x103 is applied: the next 3 responses are dropped, no request issues in DRAIN, the first new request is at 0x100, and inst_pc=0x100.
- Redirect in the same cycle as a response and an inst handshake: the response is dropped, stale = remaining outstanding, the popped entry is not re-presented, and inst_valid=0 the next cycle.
- fetch_pc=0xFFFF_FFFC: the next request address wraps to 0x0000_0000.
- With IFETCH_QUEUE_BYPASS_EN, empty FIFO, and the response arriving with inst_ready=1: inst_valid=1 in the same cycle and count stays 0. Without the macro, inst_valid rises 1 cycle later.
